// File: rtl/mem_port_sequencer_if.sv
// Bus bundle between the two requesters (fetch / data), the shared
// single-port memory and the sequencer that arbitrates between them.
interface mem_port_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IfReq;
  logic [ADDR_W-1:0] IfAddr;
  logic              IfDone;
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic              DDone;
  logic [DATA_W-1:0] RData;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWr;
  logic [DATA_W-1:0] MemRData;
  logic              Busy;

  // Sequencer side: owns the memory pins and the Done/RData returns.
  modport slave (
    input  IfReq, IfAddr, DReq, DWe, DAddr, DWData, MemRData,
    output IfDone, DDone, RData, MemAddr, MemWData, MemWr, Busy
  );

  // Requester/memory side: drives requests and memory read data.
  modport master (
    output IfReq, IfAddr, DReq, DWe, DAddr, DWData, MemRData,
    input  IfDone, DDone, RData, MemAddr, MemWData, MemWr, Busy
  );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one single-port memory between instruction fetch and data
// load/store. Round-robin grant in IDLE, fixed LATENCY-cycle access, then a
// one-cycle Done pulse to the owner with read data on RData.
module mem_port_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mem_port_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_next;
  owner_t            owner, rr_ptr;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [DATA_W-1:0] rdata;
  logic              grant;
  logic              grant_d;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and arbitration; requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.IfReq || bus.DReq) begin
          grant      = 1'b1;
          grant_d    = bus.DReq && (!bus.IfReq || (rr_ptr == OWN_D));
          state_next = ACCESS;
        end
      end
      ACCESS:  if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latching, latency counter, round-robin pointer and read capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      owner     <= OWN_IF;
      rr_ptr    <= OWN_IF;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      rdata     <= '0;
    end else if (grant) begin
      cnt       <= CNT_LOAD;
      owner     <= grant_d ? OWN_D : OWN_IF;
      rr_ptr    <= grant_d ? OWN_IF : OWN_D;
      lat_addr  <= grant_d ? bus.DAddr : bus.IfAddr;
      lat_wdata <= grant_d ? bus.DWData : '0;
      lat_we    <= grant_d && bus.DWe;
    end else if (state == ACCESS) begin
      if (cnt != 4'd0)  cnt   <= cnt - 4'd1;
      else if (!lat_we) rdata <= bus.MemRData;
    end
  end

  // Memory pins are driven only while accessing; the first ACCESS cycle is
  // the one where cnt still holds its load value.
  assign bus.MemAddr  = (state == ACCESS) ? lat_addr  : '0;
  assign bus.MemWData = (state == ACCESS) ? lat_wdata : '0;
  assign bus.MemWr    = (state == ACCESS) && lat_we && (cnt == CNT_LOAD);
  assign bus.IfDone   = (state == DONE) && (owner == OWN_IF);
  assign bus.DDone    = (state == DONE) && (owner == OWN_D);
  assign bus.RData    = rdata;
  assign bus.Busy     = (state != IDLE);

endmodule
